// File: rtl/peripheral_wb_burst_tracker.sv
// rtl/peripheral_wb_burst_tracker.sv - Wishbone B3 classic/burst acknowledge and beat address tracker
module peripheral_wb_burst_tracker #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-1:0] adr_o,
  output logic          burst_o,
  output logic          last_o,
  output logic [CW-1:0] beat_cnt_o
);

  localparam int SHIFT = $clog2(DW / 8);
  localparam int WW    = AW - SHIFT;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

  state_t        state;
  logic [WW-1:0] word_q;
  logic          incr_q;
  logic [1:0]    bte_q;

  logic          req;
  logic          cti_end;
  logic          cti_burst;
  logic          cti_bad;
  logic [WW-1:0] word_in;
  logic [WW-1:0] word_next;
  logic [CW-1:0] cnt_next;

  assign req       = wb_cyc_i & wb_stb_i;
  assign cti_end   = (wb_cti_i == 3'b000) | (wb_cti_i == 3'b111);
  assign cti_burst = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
  assign cti_bad   = ~cti_end & ~cti_burst;
  assign word_in   = WW'(wb_adr_i >> SHIFT);

  // Wrapping bursts only roll the low word-address bits; the block base stays put.
  function automatic logic [WW-1:0] advance(input logic [WW-1:0] w,
                                            input logic          incr,
                                            input logic [1:0]    bte);
    logic [WW-1:0] inc;
    inc = w + WW'(1);
    if (!incr) begin
      advance = w;
    end else begin
      case (bte)
        2'd0:    advance = inc;
        2'd1:    advance = {w[WW-1:2], inc[1:0]};
        2'd2:    advance = {w[WW-1:3], inc[2:0]};
        default: advance = {w[WW-1:4], inc[3:0]};
      endcase
    end
  endfunction

  assign word_next = advance(word_q, incr_q, bte_q);
  assign cnt_next  = (beat_cnt_o == {CW{1'b1}}) ? beat_cnt_o : beat_cnt_o + CW'(1);
  assign adr_o     = AW'(word_q) << SHIFT;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      burst_o    <= 1'b0;
      last_o     <= 1'b0;
      word_q     <= '0;
      beat_cnt_o <= '0;
      incr_q     <= 1'b0;
      bte_q      <= 2'd0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      last_o   <= 1'b0;
      case (state)
        IDLE: begin
          burst_o <= 1'b0;
          // The cycle after an error pulse is a forced gap, like after a classic ack.
          if (req && !wb_err_o) begin
            if (cti_end) begin
              state      <= CLASSIC;
              word_q     <= word_in;
              wb_ack_o   <= 1'b1;
              last_o     <= 1'b1;
              beat_cnt_o <= CW'(1);
            end else if (cti_burst) begin
              state      <= BURST;
              burst_o    <= 1'b1;
              word_q     <= word_in;
              wb_ack_o   <= 1'b1;
              beat_cnt_o <= CW'(1);
              incr_q     <= wb_cti_i[1];
              bte_q      <= wb_bte_i;
            end else begin
              wb_err_o <= 1'b1;
            end
          end
        end
        CLASSIC: begin
          state   <= IDLE;
          burst_o <= 1'b0;
        end
        BURST: begin
          if (!wb_cyc_i || last_o) begin
            state   <= IDLE;
            burst_o <= 1'b0;
          end else if (wb_stb_i) begin
            if (cti_bad) begin
              state    <= IDLE;
              burst_o  <= 1'b0;
              wb_err_o <= 1'b1;
            end else begin
              wb_ack_o   <= 1'b1;
              last_o     <= cti_end;
              word_q     <= word_next;
              beat_cnt_o <= cnt_next;
            end
          end
        end
        default: begin
          state   <= IDLE;
          burst_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_wb_burst_tracker.sv
// tb/tb_peripheral_wb_burst_tracker.sv - directed checks of the Wishbone burst tracker
module tb_peripheral_wb_burst_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        a_ack, a_err, a_burst, a_last;
  logic [31:0] a_adr;
  logic [7:0]  a_cnt;
  logic        b_ack, b_err, b_burst, b_last;
  logic [31:0] b_adr;
  logic [7:0]  b_cnt;
  logic        c_ack, c_err, c_burst, c_last;
  logic [31:0] c_adr;
  logic [1:0]  c_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  peripheral_wb_burst_tracker #(.AW(32), .DW(32), .CW(8)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_adr_i(adr), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(a_ack), .wb_err_o(a_err), .adr_o(a_adr),
    .burst_o(a_burst), .last_o(a_last), .beat_cnt_o(a_cnt)
  );

  peripheral_wb_burst_tracker #(.AW(32), .DW(64), .CW(8)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_adr_i(adr), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .adr_o(b_adr),
    .burst_o(b_burst), .last_o(b_last), .beat_cnt_o(b_cnt)
  );

  peripheral_wb_burst_tracker #(.AW(32), .DW(32), .CW(2)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_adr_i(adr), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(c_ack), .wb_err_o(c_err), .adr_o(c_adr),
    .burst_o(c_burst), .last_o(c_last), .beat_cnt_o(c_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic [31:0] a,
                       input logic [2:0] t, input logic [1:0] b);
    cyc = c; stb = s; adr = a; cti = t; bte = b;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    tick();
    chk("rst_ack",   a_ack,   0);
    chk("rst_err",   a_err,   0);
    chk("rst_burst", a_burst, 0);
    chk("rst_last",  a_last,  0);
    chk("rst_adr",   a_adr,   0);
    chk("rst_cnt",   a_cnt,   0);
    rst = 1'b0;

    // Classic request held: ack, gap, ack.
    drive(1'b1, 1'b1, 32'h100, 3'b000, 2'd0);
    tick();
    chk("cl_ack1",  a_ack,   1);
    chk("cl_last1", a_last,  1);
    chk("cl_adr1",  a_adr,   32'h100);
    chk("cl_burst", a_burst, 0);
    tick();
    chk("cl_gap_ack",  a_ack,  0);
    chk("cl_gap_last", a_last, 0);
    tick();
    chk("cl_ack3",  a_ack,  1);
    chk("cl_last3", a_last, 1);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("cl_ack4", a_ack, 0);

    // Wrap-4 burst from 0x0C.
    drive(1'b1, 1'b1, 32'h0C, 3'b010, 2'd1);
    tick();
    chk("w4_ack1",   a_ack,   1);
    chk("w4_adr1",   a_adr,   32'h0C);
    chk("w4_burst1", a_burst, 1);
    chk("w4_last1",  a_last,  0);
    chk("w4_cnt1",   a_cnt,   1);
    tick();
    chk("w4_adr2", a_adr, 32'h00);
    chk("w4_cnt2", a_cnt, 2);
    tick();
    chk("w4_adr3", a_adr, 32'h04);
    cti = 3'b111;
    tick();
    chk("w4_ack4",  a_ack,  1);
    chk("w4_adr4",  a_adr,  32'h08);
    chk("w4_last4", a_last, 1);
    chk("w4_cnt4",  a_cnt,  4);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("w4_end_ack",   a_ack,   0);
    chk("w4_end_burst", a_burst, 0);
    chk("w4_end_cnt",   a_cnt,   4);

    // Linear 64-bit burst across the top of the address space, with a wait and an abort.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8, 3'b010, 2'd0);
    tick();
    chk("lin_ack1", b_ack, 1);
    chk("lin_adr1", b_adr, 32'hFFFF_FFF8);
    tick();
    chk("lin_ack2", b_ack, 1);
    chk("lin_adr2", b_adr, 32'h0000_0000);
    stb = 1'b0;
    tick();
    chk("wait_ack1", b_ack, 0);
    chk("wait_adr1", b_adr, 32'h0);
    chk("wait_cnt1", b_cnt, 2);
    tick();
    chk("wait_ack2",   b_ack,   0);
    chk("wait_burst2", b_burst, 1);
    stb = 1'b1;
    tick();
    chk("resume_ack", b_ack, 1);
    chk("resume_adr", b_adr, 32'h8);
    chk("resume_cnt", b_cnt, 3);
    drive(1'b0, 1'b0, 32'h0, 3'b010, 2'd0);
    tick();
    chk("abort_ack",   b_ack,   0);
    chk("abort_burst", b_burst, 0);

    // Reserved cycle type.
    drive(1'b1, 1'b1, 32'h200, 3'b101, 2'd0);
    tick();
    chk("err_pulse", a_err,   1);
    chk("err_ack",   a_ack,   0);
    chk("err_burst", a_burst, 0);
    chk("err_adr",   b_adr,   32'h8);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("err_done", a_err, 0);

    // Reset in the middle of a burst.
    drive(1'b1, 1'b1, 32'h20, 3'b010, 2'd0);
    tick();
    chk("mr_ack1",   a_ack,   1);
    chk("mr_burst1", a_burst, 1);
    tick();
    chk("mr_adr2", a_adr, 32'h24);
    rst = 1'b1;
    tick();
    chk("mr_ack",   a_ack,   0);
    chk("mr_err",   a_err,   0);
    chk("mr_burst", a_burst, 0);
    chk("mr_last",  a_last,  0);
    chk("mr_adr",   a_adr,   0);
    chk("mr_cnt",   a_cnt,   0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("mr_post_ack",   a_ack,   0);
    chk("mr_post_burst", a_burst, 0);

    // Wrap-8 burst closed by a classic cycle type.
    drive(1'b1, 1'b1, 32'h11C, 3'b010, 2'd2);
    tick();
    chk("w8_adr1", a_adr, 32'h11C);
    cti = 3'b000;
    tick();
    chk("w8_ack2",  a_ack,   1);
    chk("w8_adr2",  a_adr,   32'h100);
    chk("w8_last2", a_last,  1);
    chk("w8_cnt2",  a_cnt,   2);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("w8_end_ack",   a_ack,   0);
    chk("w8_end_burst", a_burst, 0);

    // Constant-address burst with a 2-bit beat counter.
    drive(1'b1, 1'b1, 32'h40, 3'b001, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_ack",  c_ack,  1);
      chk("sat_adr",  c_adr,  32'h40);
      chk("sat_last", c_last, 0);
      chk("sat_cnt",  c_cnt,  (i > 3) ? 3 : i);
    end
    cti = 3'b111;
    tick();
    chk("sat_ack6",  c_ack,  1);
    chk("sat_last6", c_last, 1);
    chk("sat_adr6",  c_adr,  32'h40);
    chk("sat_cnt6",  c_cnt,  3);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 2'd0);
    tick();
    chk("sat_end_ack",   c_ack,   0);
    chk("sat_end_burst", c_burst, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
